// File: rtl/cnn_cell_scheduler.sv
// Sequences the shared 3x3 cell-update datapath over a W x H grid for iter_cnt iterations,
// writing clamped results into a ping-pong state RAM. Optional early stop: CNN_CONV_CHECK_EN.
module cnn_cell_scheduler #(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int AW    = 6,
  parameter int SHIFT = 0,
  parameter int YMAX  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          iter_cnt,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [AW-1:0]       rd_addr,
  input  logic signed [8:0]   rd_y,
  input  logic [7:0]          rd_u,
  output logic [80:0]         win_y,
  output logic [71:0]         win_u,
  input  logic signed [16:0]  dp_out,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [AW-1:0]       wr_addr,
  output logic signed [8:0]   wr_data
`ifdef CNN_CONV_CHECK_EN
  ,
  output logic                converged
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAT, S_CALC, S_WRITE, S_DONE} state_t;

  localparam logic [AW-1:0]          COL_LAST = AW'(W - 1);
  localparam logic [AW-1:0]          ROW_LAST = AW'(H - 1);
  localparam logic [AW-1:0]          ONE_A    = AW'(1);
  localparam logic signed [AW+1:0]   W_S      = (AW + 2)'(W);
  localparam logic signed [AW+1:0]   H_S      = (AW + 2)'(H);
  localparam logic signed [AW+1:0]   OFF_P1   = (AW + 2)'(1);
  localparam logic signed [16:0]     YMAX_S   = 17'(YMAX);
  localparam logic signed [16:0]     YMIN_S   = -YMAX_S;

  state_t            state_q, state_d;
  logic              bank_q, bank_d;
  logic [AW-1:0]     row_q, row_d, col_q, col_d;
  logic [3:0]        k_q, k_d;
  logic [7:0]        iter_q, iter_d;
  logic [80:0]       win_y_q, win_y_d;
  logic [71:0]       win_u_q, win_u_d;
  logic              pend_v_q, pend_v_d, pend_in_q, pend_in_d;
  logic [3:0]        pend_k_q, pend_k_d;
  logic signed [8:0] wr_data_q, wr_data_d;
  logic              stop_early;

`ifdef CNN_CONV_CHECK_EN
  logic chg_q, chg_d, conv_q, conv_d;
  assign stop_early = !chg_q;
  assign converged  = conv_q;
`else
  assign stop_early = 1'b0;
`endif

  // Neighbour k of the current cell: offsets (-1,0,+1) in raster order.
  logic signed [AW+1:0] dr, dc, nr, nc;
  logic                 in_grid;
  logic [AW-1:0]        nb_addr, cell_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dr = '0;
    dc = '0;
    case (k_q)
      4'd0, 4'd1, 4'd2: dr = '1;
      4'd6, 4'd7, 4'd8: dr = OFF_P1;
      default:          dr = '0;
    endcase
    case (k_q)
      4'd0, 4'd3, 4'd6: dc = '1;
      4'd2, 4'd5, 4'd8: dc = OFF_P1;
      default:          dc = '0;
    endcase
    nr      = $signed({2'b00, row_q}) + dr;
    nc      = $signed({2'b00, col_q}) + dc;
    in_grid = !nr[AW+1] && (nr < H_S) && !nc[AW+1] && (nc < W_S);
    nb_addr = AW'(nr[AW-1:0] * W + nc[AW-1:0]);
    cell_addr = AW'(row_q * W + col_q);
  end

  logic signed [16:0] s_val;
  logic signed [8:0]  clamp_y;

  always_comb begin
    s_val = dp_out >>> SHIFT;
    if (s_val > YMAX_S)      clamp_y = YMAX_S[8:0];
    else if (s_val < YMIN_S) clamp_y = YMIN_S[8:0];
    else                     clamp_y = s_val[8:0];
  end

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    iter_d    = iter_q;
    wr_data_d = wr_data_q;
    win_y_d   = win_y_q;
    win_u_d   = win_u_q;
    pend_v_d  = 1'b0;
    pend_in_d = in_grid;
    pend_k_d  = k_q;
`ifdef CNN_CONV_CHECK_EN
    chg_d     = chg_q;
    conv_d    = conv_q;
`endif

    // Read data lands one cycle after its slot was issued; boundary slots load zero.
    if (pend_v_q) begin
      win_y_d[pend_k_q*9 +: 9] = pend_in_q ? rd_y : '0;
      win_u_d[pend_k_q*8 +: 8] = pend_in_q ? rd_u : '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = iter_cnt;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          state_d = (iter_cnt == 8'd0) ? S_DONE : S_FETCH;
`ifdef CNN_CONV_CHECK_EN
          chg_d   = 1'b0;
          conv_d  = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        pend_v_d = 1'b1;
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = S_LAT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_LAT: state_d = S_CALC;
      S_CALC: begin
        wr_data_d = clamp_y;
`ifdef CNN_CONV_CHECK_EN
        if (clamp_y != win_y_q[44:36]) chg_d = 1'b1;
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_FETCH;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d  = '0;
            bank_d = ~bank_q;
            iter_d = iter_q - 8'd1;
            if (iter_q == 8'd1 || stop_early) state_d = S_DONE;
`ifdef CNN_CONV_CHECK_EN
            conv_d = !chg_q;
            chg_d  = 1'b0;
`endif
          end else begin
            row_d = row_q + ONE_A;
          end
        end else begin
          col_d = col_q + ONE_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bank_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      iter_q    <= '0;
      win_y_q   <= '0;
      win_u_q   <= '0;
      pend_v_q  <= 1'b0;
      pend_in_q <= 1'b0;
      pend_k_q  <= '0;
      wr_data_q <= '0;
`ifdef CNN_CONV_CHECK_EN
      chg_q     <= 1'b0;
      conv_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      iter_q    <= iter_d;
      win_y_q   <= win_y_d;
      win_u_q   <= win_u_d;
      pend_v_q  <= pend_v_d;
      pend_in_q <= pend_in_d;
      pend_k_q  <= pend_k_d;
      wr_data_q <= wr_data_d;
`ifdef CNN_CONV_CHECK_EN
      chg_q     <= chg_d;
      conv_q    <= conv_d;
`endif
    end
  end

  assign busy    = (state_q == S_FETCH) || (state_q == S_LAT) ||
                   (state_q == S_CALC)  || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign rd_en   = (state_q == S_FETCH) && in_grid;
  assign rd_addr = rd_en ? nb_addr : '0;
  assign rd_bank = bank_q;
  assign wr_bank = ~bank_q;
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = wr_en ? cell_addr : '0;
  assign wr_data = wr_data_q;
  assign win_y   = win_y_q;
  assign win_u   = win_u_q;

endmodule

// File: tb/tb_cnn_cell_scheduler.sv
// Self-checking bench for cnn_cell_scheduler on a 4x4 grid: vector table of runs,
// write scoreboard fed by a memory model, plus corner/reset/iteration-count sequences.
module tb_cnn_cell_scheduler;

  localparam int W = 4, H = 4, AW = 4, N = 16, LIMIT = 3000;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_sh = 1'b0, fill_en = 1'b0;
  logic [7:0] iter_cnt = 8'd0;
  logic signed [16:0] dp_val = '0, dp_out;
  logic dp_pass = 1'b0;

  logic busy, done, rd_en, rd_bank, wr_en, wr_bank;
  logic [AW-1:0] rd_addr, wr_addr;
  logic signed [8:0] rd_y, wr_data;
  logic [7:0] rd_u;
  logic [80:0] win_y;
  logic [71:0] win_u;

  logic busy_s, done_s, rd_en_s, rd_bank_s, wr_en_s, wr_bank_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s;
  logic signed [8:0] wr_data_s;
  logic [80:0] win_y_s;
  logic [71:0] win_u_s;
`ifdef CNN_CONV_CHECK_EN
  logic converged, converged_s;
`endif

  always #5 clk = ~clk;

  assign dp_out = dp_pass ? {{8{win_y[44]}}, win_y[44:36]} : dp_val;

  cnn_cell_scheduler #(.W(W), .H(H), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iter_cnt(iter_cnt),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_y(rd_y), .rd_u(rd_u), .win_y(win_y), .win_u(win_u), .dp_out(dp_out),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef CNN_CONV_CHECK_EN
    , .converged(converged)
`endif
  );

  cnn_cell_scheduler #(.W(W), .H(H), .AW(AW), .SHIFT(4)) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .start(start_sh), .iter_cnt(iter_cnt),
    .busy(busy_s), .done(done_s), .rd_en(rd_en_s), .rd_bank(rd_bank_s), .rd_addr(rd_addr_s),
    .rd_y(rd_y), .rd_u(rd_u), .win_y(win_y_s), .win_u(win_u_s), .dp_out(dp_out),
    .wr_en(wr_en_s), .wr_bank(wr_bank_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s)
`ifdef CNN_CONV_CHECK_EN
    , .converged(converged_s)
`endif
  );

  // Memory model: model arrays mm/um are copied in on fill_en, DUT writes land afterwards.
  logic signed [8:0] mm [2][N];
  logic [7:0]        um [N];
  logic signed [8:0] ymem [2][N];
  logic [7:0]        umem [N];
  logic              mb = 1'b0;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int a = 0; a < N; a++) begin
        ymem[0][a] <= mm[0][a];
        ymem[1][a] <= mm[1][a];
        umem[a]    <= um[a];
      end
    end else if (wr_en) begin
      ymem[wr_bank][wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_y <= ymem[rd_bank][rd_addr];
      rd_u <= umem[rd_addr];
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t sh_q[$];

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {wr_en, wr_addr}, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_bank", wr_bank, e.bank);
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", {wr_data}, e.data);
      end
    end
    if (rst_n && wr_en_s) begin
      if (sh_q.size() == 0) begin
        check("sh_unexpected_write", {wr_en_s, wr_addr_s}, 0);
      end else begin
        wr_t e;
        e = sh_q.pop_front();
        check("sh_wr_addr", wr_addr_s, e.addr);
        check("sh_wr_data", {wr_data_s}, e.data);
      end
    end
  end

  // Reference model of a run: pushes every expected write and returns the iteration count.
  task automatic push_model(input int iter, input logic pass, input logic signed [8:0] d,
                            output int its);
    its = 0;
    for (int i = 0; i < iter; i++) begin
`ifdef CNN_CONV_CHECK_EN
      logic chg;
      chg = 1'b0;
`endif
      for (int a = 0; a < N; a++) begin
        logic signed [8:0] v;
        v = pass ? mm[mb][a] : d;
`ifdef CNN_CONV_CHECK_EN
        if (v != mm[mb][a]) chg = 1'b1;
`endif
        mm[!mb][a] = v;
        exp_q.push_back('{bank: !mb, addr: AW'(a), data: v});
      end
      mb = !mb;
      its++;
`ifdef CNN_CONV_CHECK_EN
      if (!chg) break;
`endif
    end
  endtask

  task automatic fill();
    fill_en = 1'b1;
    @(negedge clk);
    fill_en = 1'b0;
  endtask

  task automatic run(input logic [7:0] it, input logic pass, input logic signed [8:0] d,
                     input logic with_sh, input logic signed [8:0] dsh,
                     input logic corner, input logic poke);
    int its, n;
    logic [8:0] rdv;
    logic [80:0] ey;
    logic [71:0] eu;
    rdv = '0;
    push_model(int'(it), pass, d, its);
    if (with_sh)
      for (int a = 0; a < N; a++) sh_q.push_back('{bank: 1'b0, addr: AW'(a), data: dsh});
    iter_cnt = it;
    start    = 1'b1;
    start_sh = with_sh;
    @(negedge clk);
    start    = 1'b0;
    start_sh = 1'b0;
    iter_cnt = 8'd77;
    n = 1;
    check("busy_after_start", busy, its != 0);
`ifdef CNN_CONV_CHECK_EN
    check("converged_cleared", converged, 0);
`endif
    while (!done && n < LIMIT) begin
      if (corner && n <= 9) rdv[n-1] = rd_en;
      if (corner && n == 11) begin
        ey = '0;
        eu = '0;
        for (int k = 0; k < 9; k++)
          if (k == 4 || k == 5 || k == 7 || k == 8) begin
            ey[k*9 +: 9] = 9'd5;
            eu[k*8 +: 8] = 8'd3;
          end
        check("corner_rd_en", rdv, 9'h1B0);
        check("corner_win_y", win_y, ey);
        check("corner_win_u", win_u, eu);
      end
      start = poke && (n == 50);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_latency", n, its * 192 + 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_single_pulse", {done, busy, rd_en, wr_en}, 0);
    check("queue_drained", exp_q.size(), 0);
    check("sh_queue_drained", sh_q.size(), 0);
    check("bank_after_run", rd_bank, mb);
  endtask

  typedef struct {
    logic [7:0]        it;
    logic signed [16:0] dp;
    logic signed [8:0] exp_d;
    logic signed [8:0] exp_sh;
    logic              sh;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int its, n;
    vecs[0] = '{8'd1, 17'sd100,   9'sd100,   9'sd6,     1'b1};
    vecs[1] = '{8'd1, 17'sd4000,  9'sd255,   9'sd250,   1'b1};
    vecs[2] = '{8'd1, -17'sd4000, -9'sd255,  -9'sd250,  1'b1};
    vecs[3] = '{8'd1, -17'sd33,   -9'sd33,   -9'sd3,    1'b1};
    vecs[4] = '{8'd1, 17'sd256,   9'sd255,   9'sd16,    1'b1};
    vecs[5] = '{8'd1, -17'sd256,  -9'sd255,  -9'sd16,   1'b1};
    vecs[6] = '{8'd1, 17'sh0FFFF, 9'sd255,   9'sd255,   1'b1};
    vecs[7] = '{8'd1, 17'sh10000, -9'sd255,  -9'sd255,  1'b1};
    vecs[8] = '{8'd3, 17'sd7,     9'sd7,     9'sd0,     1'b0};
    vecs[9] = '{8'd2, -17'sd1,    -9'sd1,    9'sd0,     1'b0};

    for (int a = 0; a < N; a++) begin
      mm[0][a] = 9'(a * 3 - 20);
      mm[1][a] = 9'(a * 3 + 20);
      um[a]    = 8'(a + 1);
    end

    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, rd_en, rd_bank, rd_addr, wr_en, wr_addr, wr_data}, 0);
    check("reset_win_y", win_y, 0);
    check("reset_win_u", win_u, 0);
    check("reset_wr_bank", wr_bank, 1);
    rst_n = 1'b1;
    fill();

    for (int i = 0; i < 10; i++) begin
      dp_val = vecs[i].dp;
      run(vecs[i].it, 1'b0, vecs[i].exp_d, vecs[i].sh, vecs[i].exp_sh, 1'b0, i == 9);
    end

    run(8'd0, 1'b0, 9'sd0, 1'b0, 9'sd0, 1'b0, 1'b0);

    for (int a = 0; a < N; a++) begin
      mm[0][a] = 9'sd5;
      mm[1][a] = 9'sd5;
      um[a]    = 8'd3;
    end
    fill();
    dp_val = '0;
    run(8'd1, 1'b0, 9'sd0, 1'b0, 9'sd0, 1'b1, 1'b0);

    // Reset in the middle of cell 5's fetch aborts the run without further writes.
    dp_val = 17'sd20;
    push_model(1, 1'b0, 9'sd20, its);
    iter_cnt = 8'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 63) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_remaining", exp_q.size(), 11);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_ctrl", {busy, done, rd_en, rd_bank, rd_addr, wr_en, wr_addr, wr_data}, 0);
    check("midrun_reset_win_y", win_y, 0);
    check("midrun_reset_win_u", win_u, 0);
    check("midrun_reset_wr_bank", wr_bank, 1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mb = 1'b0;
    fill();
    run(8'd1, 1'b0, 9'sd20, 1'b0, 9'sd0, 1'b0, 1'b0);

`ifdef CNN_CONV_CHECK_EN
    for (int a = 0; a < N; a++) mm[mb][a] = 9'(a * 7 - 50);
    fill();
    dp_pass = 1'b1;
    run(8'd10, 1'b1, 9'sd0, 1'b0, 9'sd0, 1'b0, 1'b0);
    dp_pass = 1'b0;
    check("converged_set", converged, 1);
    repeat (3) @(negedge clk);
    check("converged_held", converged, 1);
    run(8'd1, 1'b0, 9'sd9, 1'b0, 9'sd0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
